// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int unsigned M_MEMREAD  = 0;
    localparam int unsigned M_MEMWRITE = 1;
    localparam int unsigned M_BRANCH   = 2;

endpackage

// File: rtl/mem_access_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module mem_access_ctrl_sat_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences the EX/MEM data-memory access and stalls the pipeline until it completes.
// Optional BUSY watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [2:0]            i_M,
    input  logic [DATA_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  o_stall,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rdata_valid,
    output logic                  o_err,
    output logic [CNT_WIDTH-1:0]  o_stall_cnt
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_BUSY = 2'(BUSY);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    logic [1:0]            state, state_nxt;
    logic                  op_pending, stall_c, in_busy;
    logic                  req_nxt, we_nxt, rvalid_nxt, err_nxt;
    logic [DATA_WIDTH-1:0] addr_nxt, wdata_nxt, rdata_nxt;
    logic                  wd_clr, wd_expired;

    assign op_pending = i_valid & (i_M[M_MEMREAD] | i_M[M_MEMWRITE]);
    assign in_busy    = (state == ST_BUSY);
    assign o_stall    = stall_c & ~rst;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] wd_cnt;
    logic                 unused_branch;

    // Current BUSY cycle is the TIMEOUT_CYCLES-th one since entry.
    assign wd_expired    = (wd_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign unused_branch = i_M[M_BRANCH];

    mem_access_ctrl_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_watchdog (
        .clk (clk),
        .rst (rst),
        .clr (wd_clr),
        .en  (in_busy),
        .cnt (wd_cnt)
    );
`else
    logic unused_cfg;

    assign wd_expired = 1'b0;
    assign unused_cfg = ^{i_M[M_BRANCH], wd_clr, 32'(TIMEOUT_CYCLES)};
    assign o_err      = 1'b0;
`endif

    mem_access_ctrl_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (o_stall),
        .cnt (o_stall_cnt)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nxt  = state;
        req_nxt    = mem_req;
        we_nxt     = mem_we;
        addr_nxt   = mem_addr;
        wdata_nxt  = mem_wdata;
        rdata_nxt  = o_rdata;
        rvalid_nxt = 1'b0;
        err_nxt    = 1'b0;
        stall_c    = 1'b0;
        wd_clr     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op_pending) begin
                    stall_c   = 1'b1;
                    state_nxt = ST_BUSY;
                    req_nxt   = 1'b1;
                    we_nxt    = i_M[M_MEMWRITE];
                    addr_nxt  = i_addr;
                    wdata_nxt = i_wdata;
                    wd_clr    = 1'b1;
                end
            end
            ST_BUSY: begin
                stall_c = 1'b1;
                if (mem_ack) begin
                    state_nxt = ST_DONE;
                    req_nxt   = 1'b0;
                    if (!mem_we) begin
                        rdata_nxt  = mem_rdata;
                        rvalid_nxt = 1'b1;
                    end
                end else if (wd_expired) begin
                    state_nxt = ST_DONE;
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
        end else begin
            state         <= state_nxt;
            mem_req       <= req_nxt;
            mem_we        <= we_nxt;
            mem_addr      <= addr_nxt;
            mem_wdata     <= wdata_nxt;
            o_rdata       <= rdata_nxt;
            o_rdata_valid <= rvalid_nxt;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err <= 1'b0;
        end else begin
            o_err <= err_nxt;
        end
    end
`else
    logic unused_err;
    assign unused_err = err_nxt;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_access_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 32;
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 64;
`endif
    localparam longint CNT_MAX = (longint'(1) << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic [2:0]    i_M;
    logic [DW-1:0] i_addr, i_wdata;
    logic          mem_req, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          o_stall;
    logic [DW-1:0] o_rdata;
    logic          o_rdata_valid, o_err;
    logic [CW-1:0] o_stall_cnt;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_M(i_M), .i_addr(i_addr),
        .i_wdata(i_wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .o_stall(o_stall), .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
        .o_err(o_err), .o_stall_cnt(o_stall_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Transaction-level model: an access is either absent, in flight, or just finished.
    bit            m_busy, m_done, m_we, m_rvalid, m_err;
    logic [DW-1:0] m_addr, m_wdata, m_rdata;
    longint        m_cnt;
    int            m_wait;

    // Observation counters for the directed scenarios.
    int            n_stall, n_req, n_req_we, n_rv, n_err;
    logic [DW-1:0] last_rv_data;
    logic [DW-1:0] addr_log[$];
    bit            prev_req;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_stall();
        bit pend;
        pend = i_valid && (i_M[0] || i_M[1]);
        return !rst && (m_busy || (!m_done && pend));
    endfunction

    task automatic compare();
        chk("o_stall", 64'(o_stall), 64'(m_stall()));
        chk("mem_req", 64'(mem_req), 64'(m_busy));
        chk("mem_we", 64'(mem_we), 64'(m_we));
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        chk("o_rdata", 64'(o_rdata), 64'(m_rdata));
        chk("o_rdata_valid", 64'(o_rdata_valid), 64'(m_rvalid));
        chk("o_err", 64'(o_err), 64'(m_err));
        chk("o_stall_cnt", 64'(o_stall_cnt), 64'(m_cnt));
        if (o_stall) n_stall++;
        if (mem_req) n_req++;
        if (mem_req && mem_we) n_req_we++;
        if (o_rdata_valid) begin
            n_rv++;
            last_rv_data = o_rdata;
        end
        if (o_err) n_err++;
        if (mem_req && !prev_req) addr_log.push_back(mem_addr);
        prev_req = mem_req;
    endtask

    task automatic model_step();
        bit st;
        st = m_stall();
        if (rst) begin
            m_busy = 0; m_done = 0; m_we = 0; m_rvalid = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_cnt = 0; m_wait = 0;
        end else begin
            if (st) m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
            m_rvalid = 0;
            m_err    = 0;
            if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                m_wait++;
                if (mem_ack) begin
                    m_busy = 0;
                    m_done = 1;
                    if (!m_we) begin
                        m_rdata  = mem_rdata;
                        m_rvalid = 1;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (m_wait == int'(TO)) begin
                    m_busy  = 0;
                    m_done  = 1;
                    m_err   = 1;
                    m_rdata = '0;
                end
`endif
            end else if (i_valid && (i_M[0] || i_M[1])) begin
                m_busy  = 1;
                m_wait  = 0;
                m_we    = i_M[1];
                m_addr  = i_addr;
                m_wdata = i_wdata;
            end
        end
    endtask

    // Inputs are set by the caller just after a falling edge; outputs are checked 1ns later.
    task automatic tick();
        #1;
        compare();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_obs();
        n_stall = 0; n_req = 0; n_req_we = 0; n_rv = 0; n_err = 0;
        addr_log.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; i_valid = 1'b0; i_M = 3'b000; mem_ack = 1'b0;
        tick();
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic issue(input logic [2:0] m, input logic [DW-1:0] a, input logic [DW-1:0] d);
        i_valid = 1'b1; i_M = m; i_addr = a; i_wdata = d;
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_M = '0; i_addr = '0; i_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0; prev_req = 0;
        m_busy = 0; m_done = 0; m_we = 0; m_rvalid = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_cnt = 0; m_wait = 0;
        repeat (2) @(negedge clk);

        // Reset state
        do_reset();
        #1;
        chk("reset_req", 64'(mem_req), 64'd0);
        chk("reset_cnt", 64'(o_stall_cnt), 64'd0);

        // Load, ack on the third BUSY cycle
        do_reset();
        issue(3'b001, 32'h40, 32'h0);
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
        tick();
        chk("load_stall_cycles", 64'(n_stall), 64'd4);
        chk("load_req_cycles", 64'(n_req), 64'd3);
        chk("load_we_cycles", 64'(n_req_we), 64'd0);
        chk("load_rvalid_pulses", 64'(n_rv), 64'd1);
        chk("load_rdata", 64'(last_rv_data), 64'hDEADBEEF);
        chk("load_stall_cnt", 64'(o_stall_cnt), 64'd4);

        // Store, ack in the first BUSY cycle
        do_reset();
        issue(3'b010, 32'h100, 32'h12345678);
        tick();
        i_valid = 1'b0; mem_ack = 1'b1;
        chk("store_we", 64'(mem_we), 64'd1);
        chk("store_addr", 64'(mem_addr), 64'h100);
        chk("store_wdata", 64'(mem_wdata), 64'h12345678);
        tick();
        mem_ack = 1'b0;
        tick();
        tick();
        chk("store_stall_cycles", 64'(n_stall), 64'd2);
        chk("store_rvalid_pulses", 64'(n_rv), 64'd0);

        // Back-to-back loads at 0x0 and 0x4
        do_reset();
        issue(3'b001, 32'h0, 32'h0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        tick();
        mem_ack = 1'b0;
        chk("b2b_latency_rvalid", 64'(o_rdata_valid), 64'd1);
        i_addr = 32'h4;
        tick();
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h22222222;
        i_valid = 1'b0;
        tick();
        mem_ack = 1'b0;
        tick();
        tick();
        chk("b2b_txn_count", 64'(addr_log.size()), 64'd2);
        if (addr_log.size() == 2) begin
            chk("b2b_addr0", 64'(addr_log[0]), 64'h0);
            chk("b2b_addr1", 64'(addr_log[1]), 64'h4);
        end
        chk("b2b_stall_cnt", 64'(o_stall_cnt), 64'd4);
        chk("b2b_last_rdata", 64'(last_rv_data), 64'h22222222);

        // Reset in the second BUSY cycle, late ack afterwards
        do_reset();
        issue(3'b001, 32'h80, 32'h0);
        tick();
        i_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_stall_low", 64'(o_stall), 64'd0);
        tick();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        chk("rst_req_cleared", 64'(mem_req), 64'd0);
        chk("rst_cnt_cleared", 64'(o_stall_cnt), 64'd0);
        chk("rst_addr_cleared", 64'(mem_addr), 64'd0);
        tick();
        mem_ack = 1'b0;
        tick();
        chk("rst_late_ack_ignored", 64'(n_rv), 64'd0);
        chk("rst_no_reissue", 64'(mem_req), 64'd0);
        chk("rst_cnt_stays", 64'(o_stall_cnt), 64'd0);

        // Read+write bits: write wins
        do_reset();
        issue(3'b011, 32'h200, 32'hCAFEF00D);
        tick();
        i_valid = 1'b0;
        chk("priority_we", 64'(mem_we), 64'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("priority_no_rvalid", 64'(n_rv), 64'd0);

        // Not valid: nothing happens
        do_reset();
        i_valid = 1'b0; i_M = 3'b001; i_addr = 32'h300;
        repeat (4) tick();
        chk("invalid_no_req", 64'(n_req), 64'd0);
        chk("invalid_no_stall", 64'(n_stall), 64'd0);

`ifdef MEM_TIMEOUT_EN
        // Watchdog abort after TO BUSY cycles
        do_reset();
        issue(3'b001, 32'h10, 32'h0);
        tick();
        i_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        tick();
        tick();
        chk("to_pre_rdata", 64'(o_rdata), 64'hDEADBEEF);
        clear_obs();
        issue(3'b001, 32'h14, 32'h0);
        tick();
        i_valid = 1'b0;
        repeat (7) tick();
        chk("to_req_cycles", 64'(n_req), 64'd4);
        chk("to_err_pulses", 64'(n_err), 64'd1);
        chk("to_rvalid_pulses", 64'(n_rv), 64'd0);
        chk("to_rdata_zeroed", 64'(o_rdata), 64'd0);
`endif

        // Randomized traffic with a randomly-timed memory responder
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(199) == 0);
            i_valid = ($urandom_range(3) != 0);
            i_M     = 3'($urandom_range(7));
            i_addr  = $urandom;
            i_wdata = $urandom;
            mem_ack = mem_req ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            mem_rdata = $urandom;
            tick();
        end
        rst = 1'b0; i_valid = 1'b0; mem_ack = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
